// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller in front of the advanced debug top level (IR, IDCODE, BYPASS).
// Latency: strobes and debug_select decode registers directly; TDO is combinational, or negedge-registered with ADBG_TAP_TDO_NEGEDGE_EN.
// Backpressure: none, the TAP advances one state per rising tck_i edge.
module adbg_tap_ctrl #(
    parameter int                 IR_LEN       = 4,
    parameter logic [31:0]        IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0]  IDCODE_INSTR = 4'b0010,
    parameter logic [IR_LEN-1:0]  DEBUG_INSTR  = 4'b1000,
    parameter logic [IR_LEN-1:0]  BYPASS_INSTR = 4'b1111
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o,
    input  logic debug_tdo_i
);

    // One-hot so every strobe is a single flop output and cannot glitch.
    typedef enum logic [15:0] {
        TLR      = 16'h0001,
        RTI      = 16'h0002,
        SEL_DR   = 16'h0004,
        CAP_DR   = 16'h0008,
        SHIFT_DR = 16'h0010,
        EXIT1_DR = 16'h0020,
        PAUSE_DR = 16'h0040,
        EXIT2_DR = 16'h0080,
        UPD_DR   = 16'h0100,
        SEL_IR   = 16'h0200,
        CAP_IR   = 16'h0400,
        SHIFT_IR = 16'h0800,
        EXIT1_IR = 16'h1000,
        PAUSE_IR = 16'h2000,
        EXIT2_IR = 16'h4000,
        UPD_IR   = 16'h8000
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

    tap_state_t        state;
    tap_state_t        state_nxt;
    logic [IR_LEN-1:0] ir_reg;
    logic [IR_LEN-1:0] ir_shift;
    logic [31:0]       idcode_sr;
    logic              bypass_bit;
    logic              sel_idcode;
    logic              sel_debug;
    logic              sel_bypass;
    logic              tdo_mux;
    logic              oe_mux;

    always_ff @(posedge tck_i) begin
        if (rst_i) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = TLR;
        case (state)
            TLR:      state_nxt = tms_i ? TLR      : RTI;
            RTI:      state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_nxt = tms_i ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_nxt = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = tms_i ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_nxt = tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_nxt = tms_i ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_nxt = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = tms_i ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_nxt = tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_nxt = tms_i ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    always_comb begin
        tlr_o        = state[0];
        capture_dr_o = state[3];
        shift_dr_o   = state[4];
        pause_dr_o   = state[6];
        update_dr_o  = state[8];
    end

    assign sel_idcode     = (ir_reg == IDCODE_INSTR);
    assign sel_debug      = (ir_reg == DEBUG_INSTR);
    assign sel_bypass     = (ir_reg == BYPASS_INSTR) || !(sel_idcode || sel_debug);
    assign debug_select_o = sel_debug;

    // IR is also forced on the edge entering TLR so five TMS=1 edges leave it reset.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            ir_reg     <= IDCODE_INSTR;
            ir_shift   <= '0;
            idcode_sr  <= IDCODE_VALUE;
            bypass_bit <= 1'b0;
        end else begin
            if (state == CAP_IR)
                ir_shift <= IR_CAPTURE;
            else if (state == SHIFT_IR)
                ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};

            if (state == TLR || state_nxt == TLR)
                ir_reg <= IDCODE_INSTR;
            else if (state == UPD_IR)
                ir_reg <= ir_shift;

            if (sel_idcode) begin
                if (state == CAP_DR)
                    idcode_sr <= IDCODE_VALUE;
                else if (state == SHIFT_DR)
                    idcode_sr <= {tdi_i, idcode_sr[31:1]};
            end

            if (sel_bypass) begin
                if (state == CAP_DR)
                    bypass_bit <= 1'b0;
                else if (state == SHIFT_DR)
                    bypass_bit <= tdi_i;
            end
        end
    end

    always_comb begin
        tdo_mux = 1'b0;
        if (state[11])
            tdo_mux = ir_shift[0];
        else if (state[4]) begin
            if (sel_debug)       tdo_mux = debug_tdo_i;
            else if (sel_idcode) tdo_mux = idcode_sr[0];
            else                 tdo_mux = bypass_bit;
        end
    end

    assign oe_mux = state[11] | state[4];

`ifdef ADBG_TAP_TDO_NEGEDGE_EN
    always_ff @(negedge tck_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_o    <= tdo_mux;
            tdo_oe_o <= oe_mux;
        end
    end
`else
    assign tdo_o    = tdo_mux;
    assign tdo_oe_o = oe_mux;
`endif

endmodule
